// File: rtl/hbitspreader.sv
// hbitspreader: turns a high-bit count into a word with that many ones,
// rotating the start position across successive words.
module hbitspreader #(
  parameter int DATA_WIDTH = 16,
  parameter bit ROTATE     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(DATA_WIDTH):0]   cnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          ovf,
  output logic [$clog2(DATA_WIDTH)-1:0] ptr
);

  localparam int PW = $clog2(DATA_WIDTH);
  localparam int SW = PW + 2;
  localparam logic [SW-1:0] DW = SW'(DATA_WIDTH);

  logic                  accept;
  logic [SW-1:0]         cz;
  logic [SW-1:0]         kz;
  logic [SW-1:0]         pz;
  logic [SW-1:0]         jv;
  logic [SW-1:0]         off;
  logic [SW-1:0]         sum;
  logic [DATA_WIDTH-1:0] word;
  logic                  ovf_nxt;
  logic [PW-1:0]         ptr_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    cz      = SW'(cnt);
    pz      = SW'(ptr);
    jv      = '0;
    off     = '0;
    word    = '0;
    ovf_nxt = cz > DW;
    kz      = ovf_nxt ? DW : cz;
    // bit j is set when its distance above ptr (mod width) is below k
    for (int j = 0; j < DATA_WIDTH; j++) begin
      jv = SW'(j);
      if (jv >= pz)
        off = jv - pz;
      else
        off = jv + DW - pz;
      word[j] = off < kz;
    end
    sum = pz + kz;
    if (sum >= DW)
      sum = sum - DW;
    ptr_nxt = ROTATE ? PW'(sum) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= word;
      ovf       <= ovf_nxt;
      ptr       <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hbitspreader.sv
// Bench for hbitspreader: three instances (16/rotate, 16/fixed, 12/rotate)
// share stimulus and are checked against a per-instance reference model.
module tb_hbitspreader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  cnt = '0;
  logic        out_ready = 1'b0;

  logic        rdy_a, rdy_b, rdy_c;
  logic        ov_a, ov_b, ov_c;
  logic [15:0] d_a, d_b;
  logic [11:0] d_c;
  logic        f_a, f_b, f_c;
  logic [3:0]  p_a, p_b, p_c;

  always #5 clk = ~clk;

  hbitspreader #(.DATA_WIDTH(16), .ROTATE(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .cnt(cnt), .out_valid(ov_a), .out_ready(out_ready),
    .dout(d_a), .ovf(f_a), .ptr(p_a));

  hbitspreader #(.DATA_WIDTH(16), .ROTATE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .cnt(cnt), .out_valid(ov_b), .out_ready(out_ready),
    .dout(d_b), .ovf(f_b), .ptr(p_b));

  hbitspreader #(.DATA_WIDTH(12), .ROTATE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
    .cnt(cnt), .out_valid(ov_c), .out_ready(out_ready),
    .dout(d_c), .ovf(f_c), .ptr(p_c));

  int n_chk = 0;
  int n_fail = 0;

  int          mw[3] = '{16, 16, 12};
  bit          mr[3] = '{1'b1, 1'b0, 1'b1};
  int          mptr[3];
  logic [15:0] mdout[3];
  bit          movf[3];
  bit          mvalid;

  typedef struct {
    bit          rst;
    logic [4:0]  cnt;
    logic [15:0] dout;
    logic [3:0]  ptr;
    bit          ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] act_dout(input int i);
    case (i)
      0: return d_a;
      1: return d_b;
      default: return {4'h0, d_c};
    endcase
  endfunction

  function automatic logic [3:0] act_ptr(input int i);
    case (i)
      0: return p_a;
      1: return p_b;
      default: return p_c;
    endcase
  endfunction

  function automatic logic act_ov(input int i);
    case (i)
      0: return ov_a;
      1: return ov_b;
      default: return ov_c;
    endcase
  endfunction

  function automatic logic act_ovf(input int i);
    case (i)
      0: return f_a;
      1: return f_b;
      default: return f_c;
    endcase
  endfunction

  function automatic logic act_rdy(input int i);
    case (i)
      0: return rdy_a;
      1: return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(act_ov(i)), 32'(mvalid));
      chk($sformatf("dout[%0d]", i), 32'(act_dout(i)), 32'(mdout[i]));
      chk($sformatf("ovf[%0d]", i), 32'(act_ovf(i)), 32'(movf[i]));
      chk($sformatf("ptr[%0d]", i), 32'(act_ptr(i)), 32'(mptr[i]));
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      mptr[i] = 0;
      mdout[i] = '0;
      movf[i] = 1'b0;
    end
    mvalid = 1'b0;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input bit v, input logic [4:0] c, input bit r);
    bit acc;
    int k;
    in_valid = v;
    cnt = c;
    out_ready = r;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("in_ready[%0d]", i), 32'(act_rdy(i)), 32'(!mvalid || r));
    acc = v && (!mvalid || r);
    @(posedge clk);
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        k = (int'(c) > mw[i]) ? mw[i] : int'(c);
        mdout[i] = '0;
        for (int j = 0; j < k; j++)
          mdout[i][(mptr[i] + j) % mw[i]] = 1'b1;
        movf[i] = int'(c) > mw[i];
        if (mr[i])
          mptr[i] = (mptr[i] + k) % mw[i];
      end
      mvalid = 1'b1;
    end else if (r) begin
      mvalid = 1'b0;
    end
    #1;
    check_all();
    if (acc) begin
      chk("roundtrip16", $countones(d_a), (int'(c) > 16) ? 16 : int'(c));
      chk("roundtrip12", $countones(d_c), (int'(c) > 12) ? 12 : int'(c));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd3,  16'h0007, 4'd3,  1'b0};
    tbl[1] = '{1'b0, 5'd5,  16'h00F8, 4'd8,  1'b0};
    tbl[2] = '{1'b1, 5'd14, 16'h3FFF, 4'd14, 1'b0};
    tbl[3] = '{1'b0, 5'd4,  16'hC003, 4'd2,  1'b0};
    tbl[4] = '{1'b0, 5'd20, 16'hFFFF, 4'd2,  1'b1};
    tbl[5] = '{1'b0, 5'd16, 16'hFFFF, 4'd2,  1'b0};
    tbl[6] = '{1'b0, 5'd0,  16'h0000, 4'd2,  1'b0};
    tbl[7] = '{1'b0, 5'd1,  16'h0004, 4'd3,  1'b0};
    tbl[8] = '{1'b0, 5'd13, 16'hFFF8, 4'd0,  1'b0};

    do_reset();
    for (int t = 0; t < 9; t++) begin
      if (tbl[t].rst)
        do_reset();
      step(1'b1, tbl[t].cnt, 1'b1);
      chk($sformatf("tbl%0d_dout", t), 32'(d_a), 32'(tbl[t].dout));
      chk($sformatf("tbl%0d_ptr", t), 32'(p_a), 32'(tbl[t].ptr));
      chk($sformatf("tbl%0d_ovf", t), 32'(f_a), 32'(tbl[t].ovf));
      chk($sformatf("tbl%0d_valid", t), 32'(ov_a), 32'd1);
    end

    do_reset();
    step(1'b1, 5'd3, 1'b1);
    step(1'b1, 5'd3, 1'b1);
    chk("rot0_dout", 32'(d_b), 32'h0007);
    chk("rot0_ptr", 32'(p_b), 32'd0);

    do_reset();
    step(1'b1, 5'd10, 1'b1);
    step(1'b1, 5'd5, 1'b1);
    chk("w12_dout", 32'(d_c), 32'hC07);
    chk("w12_ptr", 32'(p_c), 32'd3);

    step(1'b1, 5'd2, 1'b0);
    for (int t = 0; t < 3; t++) begin
      step(1'b1, 5'd9, 1'b0);
      chk("bp_ready", 32'(rdy_a), 32'd0);
    end
    for (int t = 0; t < 4; t++)
      step(1'b1, 5'(t + 1), 1'b1);
    step(1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b1);

    for (int t = 0; t < 1000; t++) begin
      if (t == 500) begin
        step(1'b1, 5'd7, 1'b0);
        do_reset();
      end
      step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 20)),
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
